// File: rtl/datamem_arbiter.sv
// datamem_arbiter: shares the single-ported data memory between port 0 (LSU) and port 1 (loader/debug).
// Latency: gnt/mem_en one cycle after a request is seen in IDLE; read rvalid MEM_LAT+1 cycles after gnt.
// Backpressure: requests are held until gnt and sampled only in IDLE; DATAMEM_ARB_RR_EN selects burst-limited alternation, otherwise port 0 has fixed priority.
module datamem_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MEM_LAT   = 1,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
        $error("datamem_arbiter: MEM_LAT must be 1..7");
    end
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
        $error("datamem_arbiter: MAX_BURST must be 1..15");
    end

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic          owner;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [2:0]    lat_cnt;
    logic [DW-1:0] rdata0, rdata1;
    logic          win_vld;
    logic          winner;

`ifdef DATAMEM_ARB_RR_EN
    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);
    logic       last_owner;
    logic [3:0] burst_cnt;
`endif

    always_comb begin
        win_vld = p0_req | p1_req;
        winner  = p1_req;
        if (p0_req && p1_req) begin
`ifdef DATAMEM_ARB_RR_EN
            // burst_cnt == 0 means no burst is running yet, so the tie goes away from last_owner
            if ((burst_cnt != 4'd0) && (burst_cnt < BURST_LIM))
                winner = last_owner;
            else
                winner = ~last_owner;
`else
            winner = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        p0_rvalid = 1'b0;
        p1_rvalid = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = lat_we;
                p0_gnt    = ~owner;
                p1_gnt    = owner;
                state_nxt = lat_we ? IDLE : WAIT;
            end
            WAIT: begin
                if (lat_cnt == 3'd1)
                    state_nxt = RESP;
            end
            RESP: begin
                p0_rvalid = ~owner;
                p1_rvalid = owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_cnt   <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
`ifdef DATAMEM_ARB_RR_EN
            last_owner <= 1'b1;
            burst_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        owner     <= winner;
                        lat_we    <= winner ? p1_we    : p0_we;
                        lat_addr  <= winner ? p1_addr  : p0_addr;
                        lat_wdata <= winner ? p1_wdata : p0_wdata;
`ifdef DATAMEM_ARB_RR_EN
                        if (winner == last_owner) begin
                            if (burst_cnt != 4'd15)
                                burst_cnt <= burst_cnt + 4'd1;
                        end else begin
                            burst_cnt  <= 4'd1;
                            last_owner <= winner;
                        end
`endif
                    end
                end
                ACCESS: lat_cnt <= LAT_INIT;
                WAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (lat_cnt == 3'd1) begin
                        if (owner)
                            rdata1 <= mem_rdata;
                        else
                            rdata0 <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign p0_rdata  = rdata0;
    assign p1_rdata  = rdata1;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter: directed scenarios plus randomized two-port traffic against a transaction-level model.
module tb_datamem_arbiter;

    localparam int LAT = 2;
    localparam int MB  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       p0_req, p0_we, p1_req, p1_we;
    logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic       p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [7:0] p0_rdata, p1_rdata;
    logic       mem_en, mem_we, busy;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    datamem_arbiter #(.AW(8), .DW(8), .MEM_LAT(LAT), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory: read data appears exactly LAT cycles after the read strobe, garbage otherwise
    logic [7:0] env_mem [256];
    logic [7:0] pipe [LAT];
    always @(posedge clk) begin
        if (mem_en && mem_we) env_mem[mem_addr] <= mem_wdata;
        pipe[0] <= (mem_en && !mem_we) ? env_mem[mem_addr] : ~env_mem[mem_addr];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[LAT-1];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, got, exp);
        end
    endtask

    // transaction-level model: one access in flight, scheduled by cycle numbers
    logic [7:0] ref_mem [256];
    logic [7:0] exp_rdata [2];
    logic [7:0] exp_addr, exp_wdata, m_addr, m_wdata, m_rval;
    int m_idle_cyc = 0, m_gnt_cyc = -1, m_rv_cyc = -1, m_port = 0, m_we = 0;
    int lo = 1, bc = 0, w = 0;
    bit model_ok = 0;

    always @(negedge clk) begin
        if (model_ok) begin
            if (cyc == m_gnt_cyc) begin exp_addr = m_addr; exp_wdata = m_wdata; end
            if (cyc == m_rv_cyc) exp_rdata[m_port] = m_rval;
            chk("busy", busy, cyc < m_idle_cyc);
            chk("p0_gnt", p0_gnt, cyc == m_gnt_cyc && m_port == 0);
            chk("p1_gnt", p1_gnt, cyc == m_gnt_cyc && m_port == 1);
            chk("mem_en", mem_en, cyc == m_gnt_cyc);
            chk("mem_we", mem_we, cyc == m_gnt_cyc && m_we == 1);
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_wdata", mem_wdata, exp_wdata);
            chk("p0_rvalid", p0_rvalid, cyc == m_rv_cyc && m_port == 0);
            chk("p1_rvalid", p1_rvalid, cyc == m_rv_cyc && m_port == 1);
            chk("p0_rdata", p0_rdata, exp_rdata[0]);
            chk("p1_rdata", p1_rdata, exp_rdata[1]);
        end
        if (!rst_n) begin
            model_ok = 1;
            m_idle_cyc = cyc + 1; m_gnt_cyc = -1; m_rv_cyc = -1;
            exp_rdata[0] = 8'h00; exp_rdata[1] = 8'h00;
            exp_addr = 8'h00; exp_wdata = 8'h00;
            lo = 1; bc = 0;
        end else if (model_ok && cyc >= m_idle_cyc && (p0_req || p1_req)) begin
            if (p0_req && p1_req) begin
`ifdef DATAMEM_ARB_RR_EN
                w = (bc > 0 && bc < MB) ? lo : 1 - lo;
`else
                w = 0;
`endif
            end else begin
                w = p1_req ? 1 : 0;
            end
            if (w == lo) bc = (bc < 15) ? bc + 1 : 15;
            else begin bc = 1; lo = w; end
            m_port  = w;
            m_we    = (w == 1) ? int'(p1_we) : int'(p0_we);
            m_addr  = (w == 1) ? p1_addr : p0_addr;
            m_wdata = (w == 1) ? p1_wdata : p0_wdata;
            m_gnt_cyc = cyc + 1;
            if (m_we == 1) begin
                ref_mem[m_addr] = m_wdata;
                m_rv_cyc = -1;
                m_idle_cyc = cyc + 2;
            end else begin
                m_rval = ref_mem[m_addr];
                m_rv_cyc = cyc + 2 + LAT;
                m_idle_cyc = cyc + 3 + LAT;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 50) begin tick(); k++; end
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    function automatic logic [7:0] raddr();
        int k = $urandom_range(0, 5);
        if (k == 5) return 8'hFF;
        if (k == 4) return 8'($urandom);
        return 8'(k);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gq[$];
        int k, got;
        rst_n = 0;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            if (i == 8'h10) v = 8'h5A;
            if (i == 8'hFF) v = 8'h81;
            env_mem[i] <= v;
            ref_mem[i] = v;
        end
        for (int i = 0; i < LAT; i++) pipe[i] <= 8'h00;
        repeat (3) tick();
        rst_n = 1;
        chk("reset_busy", busy, 0);
        chk("reset_mem_addr", mem_addr, 8'h00);
        chk("reset_p0_rdata", p0_rdata, 8'h00);

        // p0 read 0x10: gnt at N+1, rvalid at N+2+LAT
        p0_req = 1; p0_we = 0; p0_addr = 8'h10;
        tick();
        chk("t1_gnt", p0_gnt, 1); chk("t1_mem_en", mem_en, 1);
        chk("t1_mem_we", mem_we, 0); chk("t1_mem_addr", mem_addr, 8'h10);
        p0_req = 0;
        repeat (LAT + 1) tick();
        chk("t1_rvalid", p0_rvalid, 1); chk("t1_rdata", p0_rdata, 8'h5A);
        chk("t1_p1_rvalid", p1_rvalid, 0);

        // p1 write 0x22 <- 0xC3, then p0 reads it back
        wait_idle();
        p1_req = 1; p1_we = 1; p1_addr = 8'h22; p1_wdata = 8'hC3;
        tick();
        chk("t2_gnt", p1_gnt, 1); chk("t2_mem_we", mem_we, 1); chk("t2_wdata", mem_wdata, 8'hC3);
        p1_req = 0;
        wait_idle();
        p0_req = 1; p0_we = 0; p0_addr = 8'h22;
        tick();
        p0_req = 0;
        repeat (LAT + 1) tick();
        chk("t2_rvalid", p0_rvalid, 1); chk("t2_rdata", p0_rdata, 8'hC3);

        // p1 read 0xFF, then a p1 write must not disturb p1_rdata
        wait_idle();
        p1_req = 1; p1_we = 0; p1_addr = 8'hFF;
        tick();
        p1_req = 0;
        repeat (LAT + 1) tick();
        chk("t3_rvalid", p1_rvalid, 1); chk("t3_rdata", p1_rdata, 8'h81);
        wait_idle();
        p1_req = 1; p1_we = 1; p1_addr = 8'h30; p1_wdata = 8'h11;
        tick();
        p1_req = 0;
        repeat (3) tick();
        chk("t3_rdata_held", p1_rdata, 8'h81);

        // reset while a read waits on memory
        wait_idle();
        p0_req = 1; p0_we = 0; p0_addr = 8'h10;
        tick();
        p0_req = 0;
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("t4_busy", busy, 0); chk("t4_mem_en", mem_en, 0);
        chk("t4_mem_addr", mem_addr, 8'h00); chk("t4_p0_rdata", p0_rdata, 8'h00);
        for (int i = 0; i < 4; i++) begin
            chk("t4_no_rvalid", p0_rvalid, 0);
            tick();
        end
        p0_req = 1; p0_we = 0; p0_addr = 8'h22;
        tick();
        chk("t4_gnt", p0_gnt, 1);
        p0_req = 0;
        repeat (LAT + 1) tick();
        chk("t4_rvalid", p0_rvalid, 1); chk("t4_rdata", p0_rdata, 8'hC3);

        // both ports requesting writes continuously
        wait_idle();
        rst_n = 0;
        tick();
        rst_n = 1;
        p0_req = 1; p0_we = 1; p0_addr = 8'h40; p0_wdata = 8'h01;
        p1_req = 1; p1_we = 1; p1_addr = 8'h41; p1_wdata = 8'h02;
        k = 0;
`ifdef DATAMEM_ARB_RR_EN
        while (gq.size() < 6 && k < 100) begin
`else
        while (gq.size() < 10 && k < 100) begin
`endif
            tick(); k++;
            if (p0_gnt) begin gq.push_back(0); p0_wdata = p0_wdata + 8'd1; end
            if (p1_gnt) begin gq.push_back(1); p1_wdata = p1_wdata + 8'd1; end
        end
`ifdef DATAMEM_ARB_RR_EN
        chk("rr_count", gq.size(), 6);
        begin
            int exp_rr[6] = '{0, 0, 1, 1, 0, 0};
            for (int i = 0; i < gq.size() && i < 6; i++) chk("rr_order", gq[i], exp_rr[i]);
        end
        p0_req = 0; p1_req = 0;
`else
        chk("fp_count", gq.size(), 10);
        for (int i = 0; i < gq.size(); i++) chk("fp_order", gq[i], 0);
        p0_req = 0;
        got = -1; k = 0;
        while (got < 0 && k < 20) begin
            tick(); k++;
            if (p0_gnt) got = 0;
            if (p1_gnt) got = 1;
        end
        chk("fp_after_drop", got, 1);
        p1_req = 0;
`endif
        wait_idle();

        // randomized traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst_n = ($urandom_range(0, 299) != 0);
            if (!p0_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    p0_req = 1; p0_we = 1'($urandom); p0_addr = raddr(); p0_wdata = 8'($urandom);
                end
            end else if (p0_gnt) begin
                if ($urandom_range(0, 1) == 0) begin
                    p0_we = 1'($urandom); p0_addr = raddr(); p0_wdata = 8'($urandom);
                end else p0_req = 0;
            end
            if (!p1_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    p1_req = 1; p1_we = 1'($urandom); p1_addr = raddr(); p1_wdata = 8'($urandom);
                end
            end else if (p1_gnt) begin
                if ($urandom_range(0, 1) == 0) begin
                    p1_we = 1'($urandom); p1_addr = raddr(); p1_wdata = 8'($urandom);
                end else p1_req = 0;
            end
        end
        rst_n = 1; p0_req = 0; p1_req = 0;
        tick();
        wait_idle();
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported 256 x 8 data memory.
- Shares the memory between the core load/store unit (port 0) and the loader/debug port (port 1).
- Registers the winning request, drives one memory access, waits out the fixed read latency, and returns registered read data with a one-cycle valid pulse.
- Fairness comes from a per-owner burst limit.

Parameters:
- AW, 8: address width; memory depth is 2^AW.
- DW, 8: data width.
- MEM_LAT, 1: memory read latency in cycles, counted from the mem_en cycle to the cycle mem_rdata is valid. Legal range 1..7.
- MAX_BURST, 4: maximum consecutive grants to one port while the other port is requesting. Legal range 1..15.

Ports:
- clk, in, 1: system clock, rising edge.
- rst_n, in, 1: synchronous reset, active-low.
- p0_req, in, 1: port 0 request. Held with p0_we/p0_addr/p0_wdata stable until p0_gnt.
- p0_we, in, 1: 1 = write, 0 = read.
- p0_addr, in, AW: access address.
- p0_wdata, in, DW: write data.
- p0_gnt, out, 1: one-cycle pulse; the request has been issued to memory.
- p0_rvalid, out, 1: one-cycle pulse; p0_rdata is valid.
- p0_rdata, out, DW: read data, held until the next port 0 read completes.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: identical signals for port 1.
- mem_en, out, 1: memory access strobe.
- mem_we, out, 1: memory write enable, valid with mem_en.
- mem_addr, out, AW: memory address.
- mem_wdata, out, DW: memory write data.
- mem_rdata, in, DW: memory read data.
- busy, out, 1: high in any state other than IDLE.

Behaviour:
- Reset: with rst_n low at a clk edge, the next state is:
  - State = IDLE.
  - All gnt, rvalid, mem_en, mem_we = 0.
  - mem_addr, mem_wdata, p0_rdata, p1_rdata = 0.
  - last_owner = 1, so port 0 wins the first tie.
  - burst_cnt = 0.
- Reset mid-operation aborts the access. No rvalid is produced and no further memory access is issued.
- IDLE:
  - Requests are sampled only in IDLE.
  - No request: stay in IDLE.
  - Exactly one request: that port wins.
  - Both request: the winner is chosen by the arbitration rule below.
  - On a win: latch owner, we, addr, wdata into registers; next state ACCESS.
- ACCESS (exactly one cycle):
  - mem_en = 1; mem_we/mem_addr/mem_wdata come from the latched registers.
  - The owner's gnt = 1.
  - Write: next state IDLE.
  - Read: next state WAIT, with the latency counter loaded to MEM_LAT.
- WAIT:
  - The counter decrements each cycle.
  - When the counter reaches 1, capture mem_rdata into the owner's rdata register; next state RESP.
- RESP (one cycle): the owner's rvalid = 1; next state IDLE.
- Latency, with the request first visible in IDLE at cycle N:
  - gnt and mem_en at N+1.
  - Read rvalid at N+2+MEM_LAT.
  - Write occupancy is 2 cycles; read occupancy is 3+MEM_LAT cycles.
- After gnt, the requester may present its next transaction or drop req. A req still high when the arbiter returns to IDLE is treated as a new request.
- Arbitration:
  - winner == last_owner: burst_cnt increments, saturating at 15.
  - Otherwise: burst_cnt = 1 and last_owner = winner.
  - Both requesting: last_owner wins if burst_cnt < MAX_BURST, else the other port wins.
  - One port requesting: burst_cnt follows the same update rule, with no limit applied.
- Writes and reads to the same address are ordered by grant order. A read granted after a write returns the written data.
- Outputs of the non-owning port stay 0 (gnt/rvalid). Its rdata is unchanged.
- Address wrap: none. addr passes through unmodified; all 2^AW addresses are legal.

Optional Feature:
- Macro: DATAMEM_ARB_RR_EN.
- Defined: burst-limited alternation, as described above.
- Undefined: fixed priority. Port 0 always wins when both request. MAX_BURST and burst_cnt are unused; port 1 may starve while port 0 requests.

Test Plan:
- Reset; memory[0x10]=0x5A; p0 read 0x10 at cycle N → p0_gnt at N+1 with mem_en=1, mem_we=0, mem_addr=0x10; p0_rvalid at N+3 with p0_rdata=0x5A; p1 outputs 0.
- p1 write 0x22←0xC3, then p0 read 0x22 → p1_gnt with mem_we=1, mem_wdata=0xC3; no p1_rvalid; p0_rdata=0xC3.
- RR_EN defined, MAX_BURST=2, both ports requesting continuously → grant order 0,0,1,1,0,0; busy never low between transactions except the IDLE cycles.
- RR_EN undefined, both requesting continuously for 10 transactions → all grants to port 0; p1_gnt only after p0_req drops.
- p0 read in WAIT with MEM_LAT=3; rst_n low for one cycle → no p0_rvalid; all outputs 0 and busy=0 on the next cycle; a fresh request is served normally.
- MEM_LAT=2, p1 read 0xFF with memory[0xFF]=0x81 → p1_rvalid at N+4 with 0x81; p1_rdata held at 0x81 through a subsequent p1 write.
